sweep_ctrl: RTL
===============

# sweep_ctrl

Sequencer for the signal generator's phase-accumulating address counter. It drives the counter's enable and increment inputs to produce a programmable frequency sweep. The enable rate is set by a prescaler and the increment is stepped from a start value to a stop value after a programmable dwell. It sits between the control/register interface and the address counter that feeds the waveform ROM.

## Interface
- WIDTH, 8, width of increment values (matches counter `incr`)
- DIV_W, 16, prescaler width
- DWELL_W, 8, dwell counter width
- Reset is rst, asynchronous, active-high; clock is clk.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  start request, sampled only in IDLE
- abort  in  1  stop sweep, return to IDLE
- start_incr  in  WIDTH  first increment value
- stop_incr  in  WIDTH  upper increment limit
- step  in  WIDTH  increment change per segment
- div  in  DIV_W  cnt_en asserted once every div+1 clocks
- dwell  in  DWELL_W  segment length = dwell+1 cnt_en pulses
- loop  in  1  1 = repeat sweep indefinitely
- cnt_en  out  1  enable to address counter
- cnt_incr  out  WIDTH  increment to address counter
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse on normal completion
- sweep_dir  out  1  0 = up, 1 = down

## Operation
- Reset values: state IDLE, cnt_en=0, cnt_incr=0, busy=0, done=0, sweep_dir=0, prescaler=0, dwell count=0.
- States are IDLE, RUN and DONE.
- IDLE, start=1:
  - capture start_incr, stop_incr, step, div, dwell and loop into shadow registers;
  - set cnt_incr=start_incr, prescaler=div, dwell count=dwell, sweep_dir=0;
  - go to RUN.
- Inputs changing during RUN have no effect. start is ignored outside IDLE.
- RUN, prescaler:
  - when prescaler==0, cnt_en=1 for that cycle and prescaler reloads div;
  - otherwise prescaler decrements.
  - div=0 gives cnt_en every cycle.
- RUN, dwell count: each cnt_en pulse with dwell count==0 ends the segment and reloads dwell. Any other pulse decrements it.
- Segment end, up direction:
  - compute next = cnt_incr + step in WIDTH+1 bits; no wrap is permitted;
  - if next <= stop, cnt_incr=next;
  - else if loop=1, cnt_incr=start;
  - else go to DONE, with cnt_incr holding its value.
- step=0: cnt_incr stays at start_incr until abort.
- start_incr > stop_incr: one segment at start_incr, then the end condition applies.
- DONE: done=1 for one cycle, busy=0, cnt_en=0, then IDLE.
- abort (any state, priority over everything but rst): next cycle state=IDLE, cnt_en=0, busy=0, done stays 0, cnt_incr holds.
- rst mid-sweep returns all registers to their reset values immediately.

## Timing
- start sampled at edge N: busy=1 and cnt_incr=start_incr from cycle N+1.
- First cnt_en occurs in cycle N+1+div.
- cnt_incr updates on the edge ending the last pulse of a segment. The counter uses the old value on that pulse and the new value on the next pulse.
- done is asserted in the cycle after the final pulse, and busy falls in that same cycle.
- cnt_en, cnt_incr and done are registered outputs with no combinational path from inputs.

## Configuration
- Macro SWEEP_TRIANGLE_EN controls triangle sweeps.
- Defined, with loop=1 and an up-direction segment end where next > stop:
  - sweep_dir becomes 1 and cnt_incr holds for one more segment.
- Defined, down-direction segment end:
  - compute cnt_incr - step in WIDTH+1 bits;
  - if the result is below start, sweep_dir becomes 0 and cnt_incr holds for one segment;
  - otherwise cnt_incr takes the decremented value.
- Endpoints are therefore dwelled twice.
- Not defined: sawtooth reload as in Operation; sweep_dir tied 0.
- Behaviour with loop=0 is identical with or without the macro.

## Test plan
- Reset asserted mid-RUN → all outputs 0 in the same cycle; state IDLE after release.
- start_incr=4, stop=12, step=4, div=0, dwell=1, loop=0, start at N:
  - cnt_en high cycles N+1..N+6;
  - cnt_incr=4,4,8,8,12,12;
  - done pulse at N+7 with busy=0.
- div=3, dwell=0, same range: cnt_en at N+4, N+8, N+12 with cnt_incr 4, 8, 12, then done.
- loop=1, range 4..12, step 4, dwell=0:
  - cnt_incr sequence 4,8,12,4,8…;
  - abort → next cycle cnt_en=0, busy=0, no done pulse.
- start=250, stop=255, step=4, dwell=0, loop=0: cnt_incr 250, 254, then done with no wrap to 2.
- SWEEP_TRIANGLE_EN, loop=1, range 4..12, step 4, dwell=0:
  - cnt_incr 4,8,12,12,8,4,4,8;
  - sweep_dir rises on the second 12 and falls on the second 4.

Source files
------------

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: frequency-sweep sequencer for the phase-accumulating address counter.
// A prescaler sets the cnt_en rate; after every (dwell+1) cnt_en pulses the
// increment steps from start_incr towards stop_incr (sawtooth reload or stop).
//
// Optional feature: define SWEEP_TRIANGLE_EN for triangle sweeps when loop=1
// (ramp back down after the top, endpoints dwelled twice). Undefined: sawtooth
// only and sweep_dir tied low.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           start request, sampled only in IDLE
//   abort           return to IDLE (priority over everything except rst)
//   start_incr      first increment value
//   stop_incr       upper increment limit
//   step            increment change per segment
//   div             cnt_en asserted once every div+1 clocks
//   dwell           segment length = dwell+1 cnt_en pulses
//   loop            1 = repeat sweep indefinitely
//   cnt_en          enable to address counter (registered)
//   cnt_incr        increment to address counter (registered)
//   busy            high while sweeping
//   done            one-cycle pulse on normal completion (registered)
//   sweep_dir       0 = up, 1 = down
module sweep_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   start_incr,
  input  logic [WIDTH-1:0]   stop_incr,
  input  logic [WIDTH-1:0]   step,
  input  logic [DIV_W-1:0]   div,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               loop,
  output logic               cnt_en,
  output logic [WIDTH-1:0]   cnt_incr,
  output logic               busy,
  output logic               done,
  output logic               sweep_dir
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q;

  // Shadow copies of the configuration, frozen for the whole sweep
  logic [WIDTH-1:0]   start_q;
  logic [WIDTH-1:0]   stop_q;
  logic [WIDTH-1:0]   step_q;
  logic [DIV_W-1:0]   div_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               loop_q;

  logic [DIV_W-1:0]   pre_q;
  logic [DWELL_W-1:0] dcnt_q;
  logic [WIDTH-1:0]   incr_q;
  logic               cnt_en_q;
  logic               busy_q;
  logic               done_q;

  logic [DIV_W-1:0]   pre_d;
  logic               tick;
  logic [WIDTH:0]     up_sum;
  logic               up_fits;
  logic [WIDTH-1:0]   incr_d;
  logic               finish;

`ifdef SWEEP_TRIANGLE_EN
  logic               dir_q;
  logic               dir_d;
  logic [WIDTH:0]     dn_diff;
  logic               dn_low;
`endif

  // Prescaler next value; a pulse happens in every cycle the prescaler reads zero
  always_comb begin
    tick  = (pre_q == '0);
    pre_d = tick ? div_q : (pre_q - DIV_W'(1));
  end

  // Increment arithmetic is one bit wider so the top never wraps
  always_comb begin
    up_sum  = {1'b0, incr_q} + {1'b0, step_q};
    up_fits = (up_sum <= {1'b0, stop_q});
  end

`ifdef SWEEP_TRIANGLE_EN
  // Segment-end decision: step up/down, turn around (holding the endpoint), or finish
  always_comb begin
    dn_diff = {1'b0, incr_q} - {1'b0, step_q};
    dn_low  = dn_diff[WIDTH] || (dn_diff[WIDTH-1:0] < start_q);
    incr_d  = incr_q;
    dir_d   = dir_q;
    finish  = 1'b0;
    if (dir_q) begin
      if (dn_low) dir_d  = 1'b0;
      else        incr_d = dn_diff[WIDTH-1:0];
    end else if (up_fits) begin
      incr_d = up_sum[WIDTH-1:0];
    end else if (loop_q) begin
      dir_d = 1'b1;
    end else begin
      finish = 1'b1;
    end
  end

  assign sweep_dir = dir_q;
`else
  // Segment-end decision: step up, reload to start, or finish
  always_comb begin
    incr_d = incr_q;
    finish = 1'b0;
    if (up_fits)     incr_d = up_sum[WIDTH-1:0];
    else if (loop_q) incr_d = start_q;
    else             finish = 1'b1;
  end

  assign sweep_dir = 1'b0;
`endif

  // Sweep FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      start_q  <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      div_q    <= '0;
      dwell_q  <= '0;
      loop_q   <= 1'b0;
      pre_q    <= '0;
      dcnt_q   <= '0;
      incr_q   <= '0;
      cnt_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SWEEP_TRIANGLE_EN
      dir_q    <= 1'b0;
`endif
    end else if (abort) begin
      state_q  <= S_IDLE;
      cnt_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_en_q <= 1'b0;
          done_q   <= 1'b0;
          if (start) begin
            start_q  <= start_incr;
            stop_q   <= stop_incr;
            step_q   <= step;
            div_q    <= div;
            dwell_q  <= dwell;
            loop_q   <= loop;
            incr_q   <= start_incr;
            pre_q    <= div;
            dcnt_q   <= dwell;
            busy_q   <= 1'b1;
            cnt_en_q <= (div == '0);
`ifdef SWEEP_TRIANGLE_EN
            dir_q    <= 1'b0;
`endif
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          pre_q    <= pre_d;
          cnt_en_q <= (pre_d == '0);
          if (tick) begin
            if (dcnt_q == '0) begin
              dcnt_q <= dwell_q;
              if (finish) begin
                // incr_q holds its final value through DONE
                state_q  <= S_DONE;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                cnt_en_q <= 1'b0;
              end else begin
                incr_q <= incr_d;
`ifdef SWEEP_TRIANGLE_EN
                dir_q  <= dir_d;
`endif
              end
            end else begin
              dcnt_q <= dcnt_q - DWELL_W'(1);
            end
          end
        end
        S_DONE: begin
          done_q   <= 1'b0;
          cnt_en_q <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q  <= S_IDLE;
          cnt_en_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_en   = cnt_en_q;
  assign cnt_incr = incr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
